// File: rtl/uart_pkg.sv
// Shared constants for the Wishbone UART transmitter: register map, CTRL/STATUS bit positions
// and the transmit FSM state encoding.
package uart_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_CTRL   = 4'h3;
    localparam logic [3:0] ADDR_BAUD   = 4'h4;
    localparam logic [3:0] ADDR_FLAGS  = 4'h5;
    localparam logic [3:0] ADDR_TXDATA = 4'h7;

    localparam int CTRL_TX_EN    = 7;
    localparam int CTRL_PAR_EN   = 6;
    localparam int CTRL_PAR_ODD  = 5;
    localparam int CTRL_TWO_STOP = 4;
    localparam int CTRL_SOFT_RST = 3;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_DONE    = 4;
    localparam int STAT_LVL_LSB = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        TX_IDLE   = S_IDLE,
        TX_START  = S_START,
        TX_DATA   = S_DATA,
        TX_PARITY = S_PARITY,
        TX_STOP   = S_STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level and synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push & (~full | pop);
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_interface.sv
// Wishbone classic slave UART transmitter with TX FIFO, parity, 1/2 stop bits and sticky flags.
// Define UART_TX_DONE_IRQ_EN to add the irq_o done interrupt and the CTRL irq_en bit.
module uart_tx_fifo_interface #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int BAUD_RST   = 433
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        err_o,
`ifdef UART_TX_DONE_IRQ_EN
    output logic        irq_o,
`endif
    output logic        uart_tx
);
    import uart_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t         state, state_next;
    logic [DIV_W-1:0]  baud_reg, frame_baud, cnt, cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [DATA_W-1:0] shift, shift_next, fifo_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              tx_en, par_en, par_odd, two_stop, irq_en;
    logic              frame_par_en, frame_two_stop, par_bit;
    logic              soft_rst, overflow, done, ovf_set;
    logic              req, access_ok, wr_ctrl, wr_baud, wr_flags, wr_txdata;
    logic              frame_start, frame_done, bit_end, tx_next;
    logic              fifo_full, fifo_empty;
    logic [31:0]       status_word, ctrl_word, read_data;
    logic              unused_bits;

    assign unused_bits = ^{sel_i, addr_i, dat_i};

    assign req       = cyc_i & stb_i & ~ack_o & ~err_o;
    assign wr_ctrl   = req & we_i & (addr_i[3:0] == ADDR_CTRL);
    assign wr_baud   = req & we_i & (addr_i[3:0] == ADDR_BAUD);
    assign wr_flags  = req & we_i & (addr_i[3:0] == ADDR_FLAGS);
    assign wr_txdata = req & we_i & (addr_i[3:0] == ADDR_TXDATA);
    assign ovf_set   = wr_txdata & fifo_full & ~frame_start;
    assign bit_end   = (cnt == '0);

    always_comb begin
        access_ok = 1'b0;
        read_data = '0;
        case (addr_i[3:0])
            ADDR_STATUS: begin
                access_ok = !we_i;
                read_data = status_word;
            end
            ADDR_CTRL: begin
                access_ok = 1'b1;
                read_data = ctrl_word;
            end
            ADDR_BAUD: begin
                access_ok = 1'b1;
                read_data = 32'(baud_reg);
            end
            ADDR_FLAGS, ADDR_TXDATA: access_ok = we_i;
            default: access_ok = 1'b0;
        endcase
    end

    always_comb begin
        status_word                       = '0;
        status_word[STAT_BUSY]            = (state != TX_IDLE);
        status_word[STAT_EMPTY]           = fifo_empty;
        status_word[STAT_FULL]            = fifo_full;
        status_word[STAT_OVF]             = overflow;
        status_word[STAT_DONE]            = done;
        status_word[STAT_LVL_LSB +: 8]    = 8'(fifo_level);
        ctrl_word                         = '0;
        ctrl_word[CTRL_TX_EN]             = tx_en;
        ctrl_word[CTRL_PAR_EN]            = par_en;
        ctrl_word[CTRL_PAR_ODD]           = par_odd;
        ctrl_word[CTRL_TWO_STOP]          = two_stop;
        ctrl_word[CTRL_IRQ_EN]            = irq_en;
    end

    // One registered response per request; ack_o/err_o high blocks the next request for a cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= req & access_ok;
            err_o <= req & ~access_ok;
            dat_o <= (req && access_ok && !we_i) ? read_data : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_en    <= 1'b0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            two_stop <= 1'b0;
            soft_rst <= 1'b0;
            baud_reg <= DIV_W'(BAUD_RST);
`ifdef UART_TX_DONE_IRQ_EN
            irq_en   <= 1'b0;
`endif
        end else begin
            soft_rst <= wr_ctrl & dat_i[CTRL_SOFT_RST];
            if (wr_ctrl) begin
                tx_en    <= dat_i[CTRL_TX_EN];
                par_en   <= dat_i[CTRL_PAR_EN];
                par_odd  <= dat_i[CTRL_PAR_ODD];
                two_stop <= dat_i[CTRL_TWO_STOP];
`ifdef UART_TX_DONE_IRQ_EN
                irq_en   <= dat_i[CTRL_IRQ_EN];
`endif
            end
            if (wr_baud) baud_reg <= dat_i[DIV_W-1:0];
        end
    end

`ifndef UART_TX_DONE_IRQ_EN
    assign irq_en = 1'b0;
`endif

    // A flag set in the same cycle as a FLAGS write wins over the clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            overflow <= 1'b0;
            done     <= 1'b0;
        end else if (soft_rst) begin
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            overflow <= (overflow & ~wr_flags) | ovf_set;
            done     <= (done & ~wr_flags) | frame_done;
        end
    end

`ifdef UART_TX_DONE_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) irq_o <= 1'b0;
        else        irq_o <= done & irq_en;
    end
`endif

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .flush     (soft_rst),
        .push      (wr_txdata),
        .push_data (dat_i[DATA_W-1:0]),
        .pop       (frame_start),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Every non-idle state holds its bit for frame_baud+1 clocks via a per-bit reloaded down-counter.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        frame_start  = 1'b0;
        frame_done   = 1'b0;
        tx_next      = 1'b1;
        if (state != TX_IDLE) cnt_next = bit_end ? frame_baud : cnt - DIV_W'(1);
        case (state)
            TX_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    frame_start  = 1'b1;
                    state_next   = TX_START;
                    cnt_next     = baud_reg;
                    shift_next   = fifo_data;
                    bit_idx_next = '0;
                end
            end
            TX_START: if (bit_end) state_next = TX_DATA;
            TX_DATA: begin
                if (bit_end) begin
                    shift_next = shift >> 1;
                    if (bit_idx == 3'(DATA_W - 1)) begin
                        bit_idx_next = '0;
                        state_next   = frame_par_en ? TX_PARITY : TX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            TX_PARITY: if (bit_end) state_next = TX_STOP;
            TX_STOP: begin
                if (bit_end) begin
                    if (frame_two_stop && bit_idx == '0) begin
                        bit_idx_next = 3'd1;
                    end else begin
                        bit_idx_next = '0;
                        state_next   = TX_IDLE;
                        frame_done   = 1'b1;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
        if (soft_rst) begin
            state_next   = TX_IDLE;
            bit_idx_next = '0;
            frame_start  = 1'b0;
            frame_done   = 1'b0;
        end
        case (state_next)
            TX_START:  tx_next = 1'b0;
            TX_DATA:   tx_next = shift_next[0];
            TX_PARITY: tx_next = par_bit;
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= TX_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            uart_tx        <= 1'b1;
            frame_baud     <= '0;
            frame_par_en   <= 1'b0;
            frame_two_stop <= 1'b0;
            par_bit        <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            uart_tx <= tx_next;
            if (frame_start) begin
                frame_baud     <= baud_reg;
                frame_par_en   <= par_en;
                frame_two_stop <= two_stop;
                par_bit        <= (^fifo_data) ^ par_odd;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_interface.sv
// Directed bench for uart_tx_fifo_interface: register access, frame bit timing, parity and stop
// options, FIFO limits, bus errors, soft/async reset and (with UART_TX_DONE_IRQ_EN) the done interrupt.
module tb_uart_tx_fifo_interface;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata;
    logic        we, cyc, stb, ack, err, uart_tx;
    logic [3:0]  sel;
`ifdef UART_TX_DONE_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_interface dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .addr_i  (addr),
        .dat_i   (wdata),
        .dat_o   (rdata),
        .we_i    (we),
        .sel_i   (sel),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .ack_o   (ack),
        .err_o   (err),
`ifdef UART_TX_DONE_IRQ_EN
        .irq_o   (irq),
`endif
        .uart_tx (uart_tx)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              output logic got_ack, output logic got_err, output logic [31:0] got_data);
        @(negedge clk);
        addr = a; we = w; wdata = d; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        got_ack = ack; got_err = err; got_data = rdata;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        logic k, e;
        logic [31:0] r;
        bus_access(a, 1'b1, d, k, e, r);
        check_output({tag, " ack/err"}, {30'b0, e, k}, 32'h1);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic k, e;
        logic [31:0] r;
        bus_access(a, 1'b0, 32'h0, k, e, r);
        check_output({tag, " ack/err"}, {30'b0, e, k}, 32'h1);
        check_output(tag, r, exp);
    endtask

    task automatic bus_error(input logic [31:0] a, input logic w, input string tag);
        logic k, e;
        logic [31:0] r;
        bus_access(a, w, 32'hFFFF_FFFF, k, e, r);
        check_output({tag, " ack/err"}, {30'b0, e, k}, 32'h2);
    endtask

    // pattern holds the line level of each bit period in transmit order, bit 0 = start bit.
    task automatic check_frame(input logic [15:0] pattern, input int nbits, input string tag);
        int waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (uart_tx !== 1'b0 && waited < 50);
        check_output({tag, " start seen"}, {31'b0, uart_tx}, 32'h0);
        if (uart_tx === 1'b0) begin
            for (int i = 0; i < nbits * 4; i++) begin
                check_output($sformatf("%s bit%0d clk%0d", tag, i / 4, i % 4),
                             {31'b0, uart_tx}, {31'b0, pattern[i / 4]});
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int starts, first_start, last_start;
        logic prev;
        starts = 0; first_start = 0; last_start = 0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = 4'hF;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset uart_tx", {31'b0, uart_tx}, 32'h1);
        check_output("reset ack", {31'b0, ack}, 32'h0);
        check_output("reset err", {31'b0, err}, 32'h0);
        check_output("reset dat_o", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        bus_read(32'h4, 32'd433, "baud reset value");
        bus_read(32'h0, 32'h0000_0002, "status after reset");
        bus_read(32'h3, 32'h0, "ctrl after reset");

        bus_write(32'h4, 32'd3, "baud=3");
        bus_write(32'h3, 32'h80, "ctrl tx_en");
        bus_write(32'h7, 32'h9A, "push 9A");
        check_frame(16'h0334, 10, "frame 9A 8N1");
        bus_read(32'h0, 32'h0000_0012, "status done idle");

        bus_write(32'h5, 32'h0, "flags clear");
        bus_write(32'h3, 32'hC0, "ctrl even parity");
        bus_write(32'h7, 32'h9A, "push 9A even");
        check_frame(16'h0534, 11, "frame 9A even");
        bus_write(32'h3, 32'hE0, "ctrl odd parity");
        bus_write(32'h7, 32'h9A, "push 9A odd");
        check_frame(16'h0734, 11, "frame 9A odd");
        bus_write(32'h3, 32'hD0, "ctrl two stop");
        bus_write(32'h7, 32'h9A, "push 9A 2stop");
        check_frame(16'h0D34, 12, "frame 9A 2stop");
        bus_read(32'h0, 32'h0000_0012, "status after 2stop");

        bus_write(32'h3, 32'h00, "ctrl tx off");
        bus_write(32'h5, 32'h0, "flags clear 2");
        for (int i = 0; i < 17; i++) bus_write(32'h7, 32'hFF, $sformatf("push %0d", i));
        bus_read(32'h0, 32'h0000_100C, "status full overflow");
        bus_write(32'h3, 32'h80, "ctrl tx on");
        prev = uart_tx;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if (prev === 1'b1 && uart_tx === 1'b0) begin
                if (starts == 0) first_start = c;
                last_start = c;
                starts++;
            end
            prev = uart_tx;
        end
        check_output("fifo frame count", starts, 32'd16);
        check_output("back-to-back spacing", last_start - first_start, 32'd615);
        bus_read(32'h0, 32'h0000_001A, "status drained");
        bus_write(32'h5, 32'h0, "flags clear 3");
        bus_read(32'h0, 32'h0000_0002, "status flags cleared");

        bus_error(32'h7, 1'b0, "read txdata");
        bus_error(32'h0, 1'b1, "write status");
        bus_error(32'h9, 1'b0, "read 0x9");
        bus_error(32'h9, 1'b1, "write 0x9");
        bus_read(32'h0, 32'h0000_0002, "status after errors");
        bus_read(32'h3, 32'h80, "ctrl after errors");
        bus_read(32'h4, 32'd3, "baud after errors");

        bus_write(32'h7, 32'h00, "push 00 a");
        bus_write(32'h7, 32'h00, "push 00 b");
        repeat (4) @(posedge clk);
        #1;
        check_output("mid data low", {31'b0, uart_tx}, 32'h0);
        bus_write(32'h3, 32'h88, "soft reset");
        @(posedge clk);
        #1;
        check_output("soft reset line high", {31'b0, uart_tx}, 32'h1);
        bus_read(32'h0, 32'h0000_0002, "status after soft reset");
        bus_read(32'h3, 32'h80, "ctrl kept");
        bus_read(32'h4, 32'd3, "baud kept");

`ifdef UART_TX_DONE_IRQ_EN
        bus_write(32'h3, 32'h84, "ctrl irq_en");
        bus_read(32'h3, 32'h84, "ctrl irq_en readback");
        bus_write(32'h7, 32'h9A, "push 9A irq");
        check_frame(16'h0334, 10, "frame 9A irq");
        @(posedge clk);
        #1;
        check_output("irq set", {31'b0, irq}, 32'h1);
        bus_write(32'h5, 32'h0, "flags clear irq");
        @(posedge clk);
        #1;
        check_output("irq cleared", {31'b0, irq}, 32'h0);
`else
        bus_write(32'h3, 32'h84, "ctrl irq_en ignored");
        bus_read(32'h3, 32'h80, "ctrl bit2 reads 0");
`endif

        bus_write(32'h7, 32'h00, "push 00 c");
        repeat (6) @(posedge clk);
        #1;
        check_output("before async reset", {31'b0, uart_tx}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async reset line high", {31'b0, uart_tx}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(32'h4, 32'd433, "baud after async reset");
        bus_read(32'h0, 32'h0000_0002, "status after async reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
